// File: rtl/pir_pkg.sv
// pir_pkg: shared types and helpers for the PIR alarm controller slice.
//   state_t      - alarm FSM state encoding (IDLE, ALARM, HOLDOFF)
//   SYNC_STAGES  - depth of the per-channel input synchroniser
//   cnt_w()      - bit width needed for a counter spanning 0..n-1 (minimum 1)
package pir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALARM   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pir_alarm_ctrl_if.sv
// pir_alarm_ctrl_if: sensor/status bundle of pir_alarm_ctrl.
//   pir_sensor, ch_enable, stop_alarm  - towards the controller
//   led, buzzer, alarm_ch, event_count - status from the controller
//   log_rd_addr, log_rd_data, log_count - event log readback (PIR_EVENT_LOG_EN only)
// modport master: the sensor/status side; modport slave: the controller.
interface pir_alarm_ctrl_if #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LOG_DEPTH = 8
);
  logic [NUM_CH-1:0] pir_sensor;
  logic [NUM_CH-1:0] ch_enable;
  logic              stop_alarm;
  logic              led;
  logic              buzzer;
  logic [NUM_CH-1:0] alarm_ch;
  logic [CNT_W-1:0]  event_count;
`ifdef PIR_EVENT_LOG_EN
  logic [$clog2(LOG_DEPTH)-1:0] log_rd_addr;
  logic [NUM_CH-1:0]            log_rd_data;
  logic [$clog2(LOG_DEPTH):0]   log_count;

  modport master (output pir_sensor, ch_enable, stop_alarm, log_rd_addr,
                  input  led, buzzer, alarm_ch, event_count, log_rd_data, log_count);
  modport slave  (input  pir_sensor, ch_enable, stop_alarm, log_rd_addr,
                  output led, buzzer, alarm_ch, event_count, log_rd_data, log_count);
`else
  modport master (output pir_sensor, ch_enable, stop_alarm,
                  input  led, buzzer, alarm_ch, event_count);
  modport slave  (input  pir_sensor, ch_enable, stop_alarm,
                  output led, buzzer, alarm_ch, event_count);
`endif
endinterface

// File: rtl/pir_debounce.sv
// pir_debounce: one PIR channel front end.
//   clk, rst_n - clock, async active-low reset
//   pin        - raw asynchronous sensor input
//   enable     - channel arm bit
//   ev         - one-cycle pulse when the debounced level rises while armed
// qual rises after DEBOUNCE_CYCLES consecutive synchronised highs; any
// synchronised low clears it, so a held sensor never re-triggers.
module pir_debounce
  import pir_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic enable,
  output logic ev
);

  localparam int unsigned     DW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          cnt;
  logic                   qual;
  logic                   qual_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      qual   <= 1'b0;
      qual_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pin};
      qual_d <= qual;
      if (!sync[SYNC_STAGES-1]) begin
        cnt  <= '0;
        qual <= 1'b0;
      end else if (!qual) begin
        // The qualifying sample itself is the DEBOUNCE_CYCLES-th high.
        if (cnt == CNT_LAST) qual <= 1'b1;
        else                 cnt  <= cnt + 1'b1;
      end
    end
  end

  assign ev = qual & ~qual_d & enable;

endmodule

// File: rtl/pir_alarm_ctrl.sv
// pir_alarm_ctrl: multi-channel PIR motion alarm controller.
//   clk, rst_n - clock, async active-low reset
//   bus        - pir_alarm_ctrl_if.slave (sensor inputs, arm mask, stop,
//                led/buzzer, triggered channel mask, saturating alarm count)
// Optional feature: define PIR_EVENT_LOG_EN for a LOG_DEPTH-entry circular
// log of the initial alarm_ch of every alarm, read oldest-first.
module pir_alarm_ctrl
  import pir_pkg::*;
#(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BUZZ_CYCLES     = 100,
  parameter int unsigned HOLDOFF_CYCLES  = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned LOG_DEPTH       = 8
) (
  input logic             clk,
  input logic             rst_n,
  pir_alarm_ctrl_if.slave bus
);

  localparam int unsigned   TW     = cnt_w(BUZZ_CYCLES);
  localparam int unsigned   HW     = cnt_w(HOLDOFF_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(BUZZ_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);

  logic [NUM_CH-1:0] ev;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pir_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.pir_sensor[i]),
      .enable(bus.ch_enable[i]),
      .ev    (ev[i])
    );
  end

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              active_q;
  logic              start;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    alarm_d = alarm_q;
    count_d = count_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|ev) begin
          state_d = ALARM;
          alarm_d = ev;
          timer_d = '0;
          start   = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
        end
      end
      ALARM: begin
        alarm_d = alarm_q | ev;
        if ((timer_q == T_LAST) || bus.stop_alarm) begin
          state_d = HOLDOFF;
          hold_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_q == H_LAST) state_d = IDLE;
        else                  hold_d  = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      hold_q   <= '0;
      alarm_q  <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      alarm_q  <= alarm_d;
      count_q  <= count_d;
      // Registered copy of "next state is ALARM" keeps led/buzzer glitch-free.
      active_q <= (state_d == ALARM);
    end
  end

  assign bus.led         = active_q;
  assign bus.buzzer      = active_q;
  assign bus.alarm_ch    = alarm_q;
  assign bus.event_count = count_q;

`ifdef PIR_EVENT_LOG_EN
  localparam int unsigned LA = $clog2(LOG_DEPTH);

  logic [NUM_CH-1:0] log_mem [LOG_DEPTH];
  logic [LA-1:0]     wr_ptr;
  logic [LA:0]       log_cnt;
  logic [LA-1:0]     oldest;
  logic [LA-1:0]     rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      log_cnt <= '0;
      for (int unsigned i = 0; i < LOG_DEPTH; i++) log_mem[i] <= '0;
    end else if (start) begin
      log_mem[wr_ptr] <= ev;
      wr_ptr          <= wr_ptr + 1'b1;
      if (log_cnt != (LA+1)'(LOG_DEPTH)) log_cnt <= log_cnt + 1'b1;
    end
  end

  // Once full, the write pointer is the oldest entry; the index wraps
  // naturally because LOG_DEPTH is a power of two.
  always_comb begin
    oldest          = (log_cnt == (LA+1)'(LOG_DEPTH)) ? wr_ptr : '0;
    rd_idx          = oldest + bus.log_rd_addr;
    bus.log_rd_data = ({1'b0, bus.log_rd_addr} < log_cnt) ? log_mem[rd_idx] : '0;
  end

  assign bus.log_count = log_cnt;
`endif

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// tb_pir_alarm_ctrl: directed self-checking bench for pir_alarm_ctrl
// (NUM_CH=3, DEBOUNCE_CYCLES=4, BUZZ_CYCLES=10, HOLDOFF_CYCLES=5, CNT_W=2).
module tb_pir_alarm_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  pir_alarm_ctrl_if #(.NUM_CH(3), .CNT_W(2), .LOG_DEPTH(8)) bus ();

  pir_alarm_ctrl #(
    .NUM_CH         (3),
    .DEBOUNCE_CYCLES(4),
    .BUZZ_CYCLES    (10),
    .HOLDOFF_CYCLES (5),
    .CNT_W          (2),
    .LOG_DEPTH      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pir;
    logic [2:0]  en;
    logic        stop;
    int unsigned cycles;
    logic        led;
    logic [2:0]  ch;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] pir, input logic [2:0] en, input logic stop,
                              input int unsigned cycles, input logic led,
                              input logic [2:0] ch, input logic [1:0] cnt);
    vec_t v;
    v.pir = pir; v.en = en; v.stop = stop; v.cycles = cycles;
    v.led = led; v.ch = ch; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic led, input logic [2:0] ch, input logic [1:0] cnt);
    chk({name, ".led"}, 32'(bus.led), 32'(led));
    chk({name, ".buzzer"}, 32'(bus.buzzer), 32'(led));
    chk({name, ".alarm_ch"}, 32'(bus.alarm_ch), 32'(ch));
    chk({name, ".event_count"}, 32'(bus.event_count), 32'(cnt));
  endtask

  task automatic do_reset();
    bus.pir_sensor = '0;
    bus.ch_enable  = 3'b111;
    bus.stop_alarm = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Ticks until led rises (bounded) and checks the count of ticks taken.
  task automatic wait_led(input string name, input int unsigned exp_lat);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.led) seen = 1'b1;
    end
    if (!seen) n = 0;
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit stayed_low;
    logic [1:0] exp_cnt [5];
`ifdef PIR_EVENT_LOG_EN
    bus.log_rd_addr = '0;
`endif
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Glitch rejection, 4-cycle pulse, channel OR-in, ch_enable masking.
    vecs.push_back(mk(3'b001, 3'b111, 1'b0, 3,  1'b0, 3'b000, 2'd0));
    vecs.push_back(mk(3'b000, 3'b111, 1'b0, 10, 1'b0, 3'b000, 2'd0));
    vecs.push_back(mk(3'b010, 3'b111, 1'b0, 4,  1'b0, 3'b000, 2'd0));
    vecs.push_back(mk(3'b000, 3'b111, 1'b0, 3,  1'b1, 3'b010, 2'd1));
    vecs.push_back(mk(3'b000, 3'b111, 1'b0, 20, 1'b0, 3'b010, 2'd1));
    vecs.push_back(mk(3'b001, 3'b111, 1'b0, 4,  1'b0, 3'b010, 2'd1));
    vecs.push_back(mk(3'b101, 3'b111, 1'b0, 3,  1'b1, 3'b001, 2'd2));
    vecs.push_back(mk(3'b101, 3'b111, 1'b0, 3,  1'b1, 3'b001, 2'd2));
    vecs.push_back(mk(3'b101, 3'b111, 1'b0, 1,  1'b1, 3'b101, 2'd2));
    vecs.push_back(mk(3'b101, 3'b111, 1'b0, 5,  1'b1, 3'b101, 2'd2));
    vecs.push_back(mk(3'b101, 3'b111, 1'b0, 1,  1'b0, 3'b101, 2'd2));
    vecs.push_back(mk(3'b000, 3'b111, 1'b0, 8,  1'b0, 3'b101, 2'd2));
    vecs.push_back(mk(3'b100, 3'b011, 1'b0, 10, 1'b0, 3'b101, 2'd2));
    vecs.push_back(mk(3'b000, 3'b111, 1'b0, 4,  1'b0, 3'b101, 2'd2));

    do_reset();
    chk_out("reset", 1'b0, 3'b000, 2'd0);

    foreach (vecs[i]) begin
      bus.pir_sensor = vecs[i].pir;
      bus.ch_enable  = vecs[i].en;
      bus.stop_alarm = vecs[i].stop;
      repeat (vecs[i].cycles) tick();
      chk_out($sformatf("vec%0d", i), vecs[i].led, vecs[i].ch, vecs[i].cnt);
    end

    // Held sensor: 7-cycle latency, exactly 10 cycles of alarm.
    do_reset();
    bus.pir_sensor = 3'b010;
    wait_led("held_latency", 7);
    chk_out("held_start", 1'b1, 3'b010, 2'd1);
    begin
      int unsigned n = 1;
      while (n < 40) begin
        tick();
        if (!bus.led) break;
        n++;
      end
      chk("held_alarm_len", 32'(n), 32'd10);
    end
    stayed_low = 1'b1;
    repeat (15) begin
      tick();
      if (bus.led) stayed_low = 1'b0;
    end
    chk("held_no_retrigger", 32'(stayed_low), 32'd1);
    chk_out("held_end", 1'b0, 3'b010, 2'd1);

    // Early stop; edge during holdoff is ignored; edge after holdoff triggers.
    do_reset();
    bus.pir_sensor = 3'b001;
    wait_led("stop_latency", 7);
    bus.pir_sensor = 3'b010;
    repeat (2) tick();
    chk("stop_pre_led", 32'(bus.led), 32'd1);
    bus.stop_alarm = 1'b1;
    tick();
    chk_out("stop_next", 1'b0, 3'b001, 2'd1);
    stayed_low = 1'b1;
    repeat (12) begin
      tick();
      if (bus.led) stayed_low = 1'b0;
    end
    chk("holdoff_ignores_ev", 32'(stayed_low), 32'd1);
    chk_out("holdoff_end", 1'b0, 3'b001, 2'd1);
    bus.stop_alarm = 1'b0;
    bus.pir_sensor = 3'b000;
    repeat (4) tick();
    bus.pir_sensor = 3'b010;
    wait_led("after_holdoff_latency", 7);
    chk_out("after_holdoff", 1'b1, 3'b010, 2'd2);
    repeat (9) tick();
    chk("timer9_led", 32'(bus.led), 32'd1);
    bus.stop_alarm = 1'b1;
    tick();
    chk("stop_and_timeout", 32'(bus.led), 32'd0);
    bus.stop_alarm = 1'b0;
    bus.pir_sensor = 3'b000;
    repeat (10) tick();
    chk_out("stop_timeout_end", 1'b0, 3'b010, 2'd2);

    // Saturating count, then asynchronous reset mid-alarm.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.pir_sensor = 3'b001;
      wait_led($sformatf("sat%0d_latency", i), 7);
      chk($sformatf("sat%0d_count", i), 32'(bus.event_count), 32'(exp_cnt[i]));
      bus.pir_sensor = 3'b000;
      repeat (16) tick();
    end
    bus.pir_sensor = 3'b001;
    wait_led("rst_alarm_latency", 7);
    repeat (2) tick();
    chk("rst_pre_led", 32'(bus.led), 32'd1);
    rst_n = 1'b0;
    #2;
    chk_out("async_reset", 1'b0, 3'b000, 2'd0);
    bus.pir_sensor = 3'b000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

`ifdef PIR_EVENT_LOG_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.pir_sensor = 3'(1 << (i % 3));
      wait_led($sformatf("log%0d_latency", i), 7);
      bus.pir_sensor = 3'b000;
      repeat (16) tick();
    end
    chk("log_count", 32'(bus.log_count), 32'd8);
    bus.log_rd_addr = 3'd0;
    #1;
    chk("log_oldest", 32'(bus.log_rd_data), 32'(3'b100));
    bus.log_rd_addr = 3'd7;
    #1;
    chk("log_newest", 32'(bus.log_rd_data), 32'(3'b001));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
